// File: rtl/snake_pkg.sv
// snake_pkg: direction encoding, press priority and arbitration helpers for the snake input front end.
package snake_pkg;
  typedef logic [1:0] dir_t;
  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_DOWN  = 2'd1;
  localparam dir_t DIR_LEFT  = 2'd2;
  localparam dir_t DIR_RIGHT = 2'd3;
  localparam dir_t PRIO [4] = '{DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT};
  function automatic dir_t f_pick(input logic [3:0] ev);
    dir_t d;
    d = PRIO[3];
    for (int i = 3; i >= 0; i--) if (ev[PRIO[i]]) d = PRIO[i];
    return d;
  endfunction
  function automatic dir_t f_opp(input dir_t d);
    return d ^ 2'b01;
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser, stable-level debounce counter and rising-edge press pulse.
module btn_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic I_clk,
  input  logic I_rst_n,
  input  logic I_btn,
  output logic O_press
);
  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES - 1);
  logic [1:0]    r_sync;
  logic          r_stable;
  logic          r_prev;
  logic [CW-1:0] r_cnt;
  always_ff @(posedge I_clk or negedge I_rst_n)
    if (!I_rst_n) begin
      r_sync   <= '0;
      r_stable <= 1'b0;
      r_prev   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync <= {r_sync[0], I_btn};
      r_prev <= r_stable;
      if (r_sync[1] == r_stable) r_cnt <= '0;
      else if (r_cnt == CMAX) begin
        r_stable <= r_sync[1];
        r_cnt    <= '0;
      end else r_cnt <= r_cnt + 1'b1;
    end
  assign O_press = r_stable & ~r_prev;
endmodule

// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: debounced direction buttons, press arbitration, reversal rejection and a turn queue
// released one entry per move tick.
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter int   DEB_CYCLES = 1000000,
  parameter int   QDEPTH     = 2,
  parameter dir_t INIT_DIR   = DIR_RIGHT
) (
  input  logic                         I_clk,
  input  logic                         I_rst_n,
  input  logic                         I_button_u,
  input  logic                         I_button_d,
  input  logic                         I_button_l,
  input  logic                         I_button_r,
  input  logic                         I_load,
  input  logic                         I_drive,
  output dir_t                         O_dir,
  output logic [$clog2(QDEPTH+1)-1:0]  O_q_count,
  output logic                         O_drop
);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [PW-1:0] PMAX  = PW'(QDEPTH - 1);
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);
  logic [3:0]    w_raw;
  logic [3:0]    w_ev;
  dir_t          r_q [QDEPTH];
  dir_t          r_dir;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_cnt;
  logic          r_drop;
  dir_t          w_cand;
  dir_t          w_ref;
  logic [PW-1:0] w_last;
  logic [PW-1:0] w_head_nx;
  logic [PW-1:0] w_tail_nx;
  logic          w_pop;
  logic          w_push;
  logic          w_multi;
  logic          w_rej;
  assign w_raw = {I_button_r, I_button_l, I_button_d, I_button_u};
  for (genvar g = 0; g < 4; g++) begin : g_btn
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .I_clk   (I_clk),
      .I_rst_n (I_rst_n),
      .I_btn   (w_raw[g]),
      .O_press (w_ev[g])
    );
  end
  // Reference is the most recently queued turn, so reversal checks chain through buffered turns.
  always_comb begin
    w_cand    = f_pick(w_ev);
    w_last    = (r_tail == '0) ? PMAX : r_tail - 1'b1;
    w_head_nx = (r_head == PMAX) ? '0 : r_head + 1'b1;
    w_tail_nx = (r_tail == PMAX) ? '0 : r_tail + 1'b1;
    w_ref     = (r_cnt != '0) ? r_q[w_last] : r_dir;
    w_pop     = I_drive && (r_cnt != '0);
    w_multi   = (w_ev & (w_ev - 4'd1)) != 4'd0;
    w_push    = (w_ev != 4'd0) && (w_cand != w_ref) && (w_cand != f_opp(w_ref))
                && ((r_cnt - CW'(w_pop)) != QFULL);
    w_rej     = (w_ev != 4'd0) && !w_push;
  end
  always_ff @(posedge I_clk or negedge I_rst_n)
    if (!I_rst_n) begin
      r_dir  <= INIT_DIR;
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
      r_drop <= 1'b0;
      for (int i = 0; i < QDEPTH; i++) r_q[i] <= DIR_UP;
    end else if (I_load) begin
      r_dir  <= INIT_DIR;
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
      r_drop <= 1'b0;
    end else begin
      r_drop <= w_multi | w_rej;
      if (w_pop) begin
        r_dir  <= r_q[r_head];
        r_head <= w_head_nx;
      end
      if (w_push) begin
        r_q[r_tail] <= w_cand;
        r_tail      <= w_tail_nx;
      end
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  assign O_dir     = r_dir;
  assign O_q_count = r_cnt;
  assign O_drop    = r_drop;
endmodule
